// File: rtl/ov7670_fb_writer.sv
// OV7670 capture into the TFT frame buffer: the camera bus is oversampled in the tft_clk domain,
// byte pairs are assembled into RGB565 pixels, and writes are clipped to an H_ACTIVE x V_ACTIVE window.
module ov7670_fb_writer #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              tft_clk,
    input  logic              rst,
    input  logic              capture_en,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [15:0]       fb_wdata,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              short_frame
);

    localparam int unsigned COL_W  = $clog2(H_ACTIVE + 1);
    localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0] pclk_sync;
    logic [1:0] vsync_sync;
    logic [1:0] href_sync;
    logic [7:0] data_meta;
    logic [7:0] data_sync;
    logic       pclk_prev;
    logic       vsync_prev;
    logic       href_prev;

    logic pclk_rise;
    logic vsync_rise;
    logic vsync_fall;
    logic href_rise;
    logic href_fall;

    logic in_active;
    logic end_frame;
    logic clear_frame;

    logic              byte_phase;
    logic [7:0]        hi_byte;
    logic [COL_W-1:0]  col_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [ADDR_W-1:0] line_base;

    logic col_room;
    logic line_room;
    logic sample_hi;
    logic pixel_formed;
    logic write_now;
    logic line_end;

    // Every camera signal gets the same two-stage depth so pclk stays aligned with data/href.
    always_ff @(posedge tft_clk) begin
        if (rst) begin
            pclk_sync  <= '0;
            vsync_sync <= '0;
            href_sync  <= '0;
            data_meta  <= '0;
            data_sync  <= '0;
            pclk_prev  <= 1'b0;
            vsync_prev <= 1'b0;
            href_prev  <= 1'b0;
        end else begin
            pclk_sync  <= {pclk_sync[0], cam_pclk};
            vsync_sync <= {vsync_sync[0], cam_vsync};
            href_sync  <= {href_sync[0], cam_href};
            data_meta  <= cam_data;
            data_sync  <= data_meta;
            pclk_prev  <= pclk_sync[1];
            vsync_prev <= vsync_sync[1];
            href_prev  <= href_sync[1];
        end
    end

    assign pclk_rise  = pclk_sync[1] & ~pclk_prev;
    assign vsync_rise = vsync_sync[1] & ~vsync_prev;
    assign vsync_fall = ~vsync_sync[1] & vsync_prev;
    assign href_rise  = href_sync[1] & ~href_prev;
    assign href_fall  = ~href_sync[1] & href_prev;

    always_ff @(posedge tft_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture_en) begin
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (!capture_en) begin
                    state_next = IDLE;
                end else if (vsync_fall) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                // capture_en is only looked at once the frame has ended
                if (vsync_rise) begin
                    state_next = capture_en ? WAIT_FRAME : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_active   = (state == ACTIVE);
        end_frame   = in_active & vsync_rise;
        clear_frame = ~in_active;
    end

    assign col_room  = (col_cnt < COL_MAX);
    assign line_room = (line_cnt < LINE_MAX);

    // A href rising edge forces phase 0 even when it lands on the same cycle as the first byte.
    assign sample_hi    = in_active & pclk_rise & href_sync[1] & (~byte_phase | href_rise);
    assign pixel_formed = in_active & pclk_rise & href_sync[1] & byte_phase & ~href_rise;
    assign write_now    = pixel_formed & col_room & line_room & ~vsync_rise;
    assign line_end     = in_active & href_fall & (col_cnt != '0);

    always_ff @(posedge tft_clk) begin
        if (rst || clear_frame) begin
            byte_phase <= 1'b0;
            hi_byte    <= '0;
            col_cnt    <= '0;
            line_cnt   <= '0;
            line_base  <= '0;
        end else begin
            if (href_rise) begin
                byte_phase <= 1'b0;
            end
            if (sample_hi) begin
                hi_byte    <= data_sync;
                byte_phase <= 1'b1;
            end else if (pixel_formed) begin
                byte_phase <= 1'b0;
                if (col_room) begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end
            if (line_end) begin
                col_cnt <= '0;
                if (line_room) begin
                    line_cnt  <= line_cnt + LINE_W'(1);
                    line_base <= line_base + LINE_STEP;
                end
            end
        end
    end

    always_ff @(posedge tft_clk) begin
        if (rst) begin
            fb_we       <= 1'b0;
            fb_waddr    <= '0;
            fb_wdata    <= '0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            short_frame <= 1'b0;
        end else begin
            fb_we      <= write_now;
            frame_done <= end_frame;
            if (write_now) begin
                fb_waddr <= line_base + ADDR_W'(col_cnt);
                fb_wdata <= {hi_byte, data_sync};
            end
            if (end_frame) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (line_room) begin
                    short_frame <= 1'b1;
                end
            end
        end
    end

endmodule
